// File: rtl/seq_shift_add_mult_pkg.sv
// Shared types and helpers for the sequential shift-and-add multiplier.
package seq_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width needed to count multiplier bits from 0 up to and including bw.
    function automatic int cnt_width(input int bw);
        return $clog2(bw + 1);
    endfunction

endpackage

// File: rtl/seq_shift_add_mult_shift_add_step.sv
// One iteration of the multiplier datapath: adds BPC shifted partial products to acc.
module shift_add_step #(
    parameter int AW  = 8,
    parameter int BW  = 8,
    parameter int BPC = 1,
    parameter int CW  = 4
) (
    input  logic [AW+BW-1:0] acc,
    input  logic [AW-1:0]    a_reg,
    input  logic [BPC-1:0]   b_slice,
    input  logic [CW-1:0]    count,
    output logic [AW+BW-1:0] acc_next
);

    localparam int PW = AW + BW;

    logic [PW-1:0] sum;

    always_comb begin
        sum = acc;
        for (int k = 0; k < BPC; k++) begin
            if (b_slice[k]) begin
                sum = sum + (PW'(a_reg) << (count + k));
            end
        end
        acc_next = sum;
    end

endmodule

// File: rtl/seq_shift_add_mult.sv
// Multi-cycle shift-and-add multiplier retiring BPC multiplier bits per clock.
// Optional early termination on an exhausted multiplier: define SEQ_MULT_EARLY_TERM_EN.
module seq_shift_add_mult
    import seq_mult_pkg::*;
#(
    parameter int AW  = 8,
    parameter int BW  = 8,
    parameter int BPC = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [AW-1:0]    a,
    input  logic [BW-1:0]    b,
    input  logic             is_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [AW+BW-1:0] product,
    output logic             busy
);

    localparam int PW = AW + BW;
    localparam int CW = cnt_width(BW);

    state_t        state;
    state_t        state_next;
    logic [AW-1:0] a_reg;
    logic [BW-1:0] b_reg;
    logic [PW-1:0] acc;
    logic [PW-1:0] acc_next;
    logic [CW-1:0] count;
    logic          neg;
    logic          finalize;
    logic [AW-1:0] a_mag;
    logic [BW-1:0] b_mag;

    // Operands are held as unsigned magnitudes; -2^(N-1) maps to 2^(N-1) in N bits.
    assign a_mag = (is_signed && a[AW-1]) ? -a : a;
    assign b_mag = (is_signed && b[BW-1]) ? -b : b;

    shift_add_step #(
        .AW (AW),
        .BW (BW),
        .BPC(BPC),
        .CW (CW)
    ) u_step (
        .acc     (acc),
        .a_reg   (a_reg),
        .b_slice (b_reg[BPC-1:0]),
        .count   (count),
        .acc_next(acc_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        finalize   = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
`ifdef SEQ_MULT_EARLY_TERM_EN
                finalize = (b_reg == '0);
`else
                finalize = (count == CW'(BW));
`endif
                if (finalize) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: capture on accept, iterate in RUN, apply the sign once when finishing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg   <= '0;
            b_reg   <= '0;
            acc     <= '0;
            count   <= '0;
            neg     <= 1'b0;
            product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg <= a_mag;
                        b_reg <= b_mag;
                        neg   <= is_signed & (a[AW-1] ^ b[BW-1]);
                        acc   <= '0;
                        count <= '0;
                    end
                end
                RUN: begin
                    if (finalize) begin
                        product <= neg ? -acc : acc;
                    end else begin
                        acc   <= acc_next;
                        b_reg <= b_reg >> BPC;
                        count <= count + CW'(BPC);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Self-checking bench: BPC=1 and BPC=4 multipliers driven in lockstep against an arithmetic reference.
module tb_seq_shift_add_mult;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  a = '0;
    logic [7:0]  b = '0;
    logic        is_signed = 1'b0;
    logic        out_ready = 1'b0;

    logic        in_ready1, out_valid1, busy1;
    logic [15:0] product1;
    logic        in_ready4, out_valid4, busy4;
    logic [15:0] product4;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seq_shift_add_mult #(.AW(8), .BW(8), .BPC(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .a(a), .b(b), .is_signed(is_signed), .out_valid(out_valid1),
        .out_ready(out_ready), .product(product1), .busy(busy1)
    );

    seq_shift_add_mult #(.AW(8), .BW(8), .BPC(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
        .a(a), .b(b), .is_signed(is_signed), .out_valid(out_valid4),
        .out_ready(out_ready), .product(product4), .busy(busy4)
    );

    task automatic checkOutput(input string tag, input longint actual, input longint expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic logic [15:0] ref_mult(input logic [7:0] av, input logic [7:0] bv, input logic sg);
        longint sa;
        longint sb;
        sa = longint'(av);
        sb = longint'(bv);
        if (sg && av[7]) sa = sa - 256;
        if (sg && bv[7]) sb = sb - 256;
        return 16'(sa * sb);
    endfunction

    // Cycles from the accept edge until out_valid is seen high.
    function automatic int exp_lat(input logic [7:0] bv, input logic sg, input int bpc);
        logic [7:0] m;
        int         nbits;
        m = (sg && bv[7]) ? -bv : bv;
        nbits = 0;
        for (int i = 0; i < 8; i++) begin
            if (m[i]) nbits = i + 1;
        end
`ifdef SEQ_MULT_EARLY_TERM_EN
        return (nbits + bpc - 1) / bpc + 1;
`else
        if (nbits < 0) return 0;
        return 8 / bpc + 1;
`endif
    endfunction

    task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv, input logic sg, input string tag);
        logic [15:0] exp_p;
        logic [15:0] p1;
        logic [15:0] p4;
        int          got1;
        int          got4;
        exp_p = ref_mult(av, bv, sg);
        got1 = -1;
        got4 = -1;
        p1 = '0;
        p4 = '0;
        @(negedge clk);
        a = av;
        b = bv;
        is_signed = sg;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
        is_signed = 1'($urandom);
        for (int c = 0; c < 40 && (got1 < 0 || got4 < 0); c++) begin
            if (c > 0) @(negedge clk);
            if (c == 0) begin
                checkOutput({tag, "_busy"}, longint'(busy1), 1);
                checkOutput({tag, "_in_ready"}, longint'(in_ready1), 0);
            end
            if (got1 < 0 && out_valid1) begin
                got1 = c;
                p1 = product1;
            end
            if (got4 < 0 && out_valid4) begin
                got4 = c;
                p4 = product4;
            end
        end
        checkOutput({tag, "_lat1"}, got1, exp_lat(bv, sg, 1));
        checkOutput({tag, "_lat4"}, got4, exp_lat(bv, sg, 4));
        checkOutput({tag, "_prod1"}, longint'(p1), longint'(exp_p));
        checkOutput({tag, "_prod4"}, longint'(p4), longint'(exp_p));
    endtask

    initial begin
        #12;
        checkOutput("reset_in_ready", longint'(in_ready1), 1);
        checkOutput("reset_out_valid", longint'(out_valid1), 0);
        checkOutput("reset_busy", longint'(busy1), 0);
        checkOutput("reset_product", longint'(product1), 0);
        @(negedge clk);
        rst = 1'b0;

        applyStimulus(8'd13, 8'd11, 1'b0, "u13x11");
        checkOutput("u13x11_const", longint'(product1), 16'h008F);
        applyStimulus(8'hFB, 8'd7, 1'b1, "sm5x7");
        checkOutput("sm5x7_const", longint'(product1), 16'hFFDD);
        applyStimulus(8'h80, 8'h80, 1'b1, "sm128sq");
        checkOutput("sm128sq_const", longint'(product4), 16'h4000);
        applyStimulus(8'hFF, 8'hFF, 1'b0, "u255sq");
        checkOutput("u255sq_const", longint'(product1), 16'hFE01);
        applyStimulus(8'd200, 8'd3, 1'b0, "u200x3");
        checkOutput("u200x3_const", longint'(product4), 16'd600);
        applyStimulus(8'd77, 8'd0, 1'b0, "bzero");
        applyStimulus(8'd77, 8'd1, 1'b1, "bone");

        // Backpressure: product held while the consumer stalls, new operands ignored.
        @(negedge clk);
        a = 8'd9;
        b = 8'd6;
        is_signed = 1'b0;
        in_valid = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        begin
            int waited;
            waited = 0;
            while (!(out_valid1 && out_valid4) && waited < 40) begin
                @(negedge clk);
                waited++;
            end
            checkOutput("bp_reach_done", longint'(out_valid1 && out_valid4), 1);
        end
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            a = 8'($urandom);
            b = 8'($urandom);
            @(negedge clk);
            checkOutput("bp_hold_prod1", longint'(product1), 54);
            checkOutput("bp_hold_prod4", longint'(product4), 54);
            checkOutput("bp_in_ready", longint'(in_ready1), 0);
            checkOutput("bp_out_valid", longint'(out_valid1), 1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_release_in_ready1", longint'(in_ready1), 1);
        checkOutput("bp_release_in_ready4", longint'(in_ready4), 1);
        checkOutput("bp_release_out_valid", longint'(out_valid1), 0);
        checkOutput("bp_release_prod", longint'(product1), 54);

        // Asynchronous reset in the middle of an operation.
        @(negedge clk);
        a = 8'd200;
        b = 8'd150;
        is_signed = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("mid_busy", longint'(busy1), 1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("arst_in_ready", longint'(in_ready1), 1);
        checkOutput("arst_out_valid", longint'(out_valid1), 0);
        checkOutput("arst_busy", longint'(busy1), 0);
        checkOutput("arst_prod1", longint'(product1), 0);
        checkOutput("arst_prod4", longint'(product4), 0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(8'd3, 8'd4, 1'b0, "after_reset");

        for (int i = 0; i < 1000; i++) begin
            applyStimulus(8'($urandom), 8'($urandom), 1'($urandom), "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
